// File: rtl/store_narrow_unit_if.sv
// ---------------------------------------------------------------------------
// store_narrow_unit_if
//   Bundles the store request handshake from the MEM stage, the byte-wide
//   data-memory write port and the completion/fault pulses returned to the
//   pipeline controller.
//
//   Request side : req_valid, req_ready, req_addr[31:0], req_data[31:0],
//                  req_size[1:0] (00 byte, 01 half, 10 word, 11 illegal)
//   Memory side  : mem_wvalid, mem_wready, mem_waddr[31:0], mem_wdata[7:0]
//   Status       : done (store finished), fault (misaligned / illegal size)
//
//   slave  : view taken by the narrowing unit
//   master : view taken by the pipeline / memory model driving the unit
// ---------------------------------------------------------------------------
interface store_narrow_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        done;
    logic        fault;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_wready,
        output req_ready, mem_wvalid, mem_waddr, mem_wdata, done, fault
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_wready,
        input  req_ready, mem_wvalid, mem_waddr, mem_wdata, done, fault
    );
endinterface

// File: rtl/store_narrow_unit.sv
// ---------------------------------------------------------------------------
// store_narrow_unit
//   Store-path narrowing unit for the 32-bit MIPS datapath. Takes a register
//   value plus a store size, truncates it to 8/16/32 bits, checks alignment
//   and streams the retained bytes one per beat onto the byte-wide memory
//   write port.
//
//   Parameters
//     BIG_ENDIAN : 1 = most-significant retained byte at the lowest address,
//                  0 = least-significant byte at the lowest address.
//   Ports
//     clk   : rising-edge clock
//     reset : synchronous active-high reset
//     bus   : store_narrow_unit_if.slave (request, memory write, done/fault)
//
//   All outputs are registered. The next beat's address and data are
//   computed combinationally and loaded into the output registers at the
//   edge where a request is accepted or the current beat is taken, so the
//   beat presented on the port never changes while mem_wready is low.
// ---------------------------------------------------------------------------
module store_narrow_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    store_narrow_unit_if.slave    bus
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_reg;
    logic [31:0] base_reg;
    logic [31:0] data_reg;
    logic [1:0]  last_reg;      // index of the final beat: 0, 1 or 3
    logic [1:0]  index_reg;

    logic        req_ready_reg;
    logic        mem_wvalid_reg;
    logic [31:0] mem_waddr_reg;
    logic [7:0]  mem_wdata_reg;
    logic        done_reg;
    logic        fault_reg;

    // Request decode: legality, truncated value and final beat index.
    logic        req_legal;
    logic [31:0] req_trunc;
    logic [1:0]  req_last;

    always_comb begin
        req_legal = 1'b0;
        req_trunc = {24'd0, bus.req_data[7:0]};
        req_last  = 2'd0;
        case (bus.req_size)
            2'b00: begin
                req_legal = 1'b1;
            end
            2'b01: begin
                req_legal = ~bus.req_addr[0];
                req_trunc = {16'd0, bus.req_data[15:0]};
                req_last  = 2'd1;
            end
            2'b10: begin
                req_legal = (bus.req_addr[1:0] == 2'b00);
                req_trunc = bus.req_data;
                req_last  = 2'd3;
            end
            default: begin
                req_legal = 1'b0;
            end
        endcase
    end

    // Source of the beat to be loaded at the next edge: the incoming request
    // while idle, otherwise the following beat of the latched store.
    logic [31:0] src_data;
    logic [31:0] src_base;
    logic [1:0]  src_last;
    logic [1:0]  src_index;
    logic [7:0]  src_lane [4];
    logic [1:0]  beat_sel;
    logic [31:0] beat_addr;
    logic [7:0]  beat_data;

    always_comb begin
        src_data  = data_reg;
        src_base  = base_reg;
        src_last  = last_reg;
        src_index = index_reg + 2'd1;
        if (state_reg == IDLE) begin
            src_data  = req_trunc;
            src_base  = bus.req_addr;
            src_last  = req_last;
            src_index = 2'd0;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign src_lane[gi] = src_data[gi*8 +: 8];
    end

    // Big-endian beat i carries byte (last - i); the address add wraps
    // naturally at 2^32.
    assign beat_sel  = BIG_ENDIAN ? (src_last - src_index) : src_index;
    assign beat_data = src_lane[beat_sel];
    assign beat_addr = src_base + {30'd0, src_index};

    logic beat_fire;
    logic last_beat;
    assign beat_fire = mem_wvalid_reg & bus.mem_wready;
    assign last_beat = (index_reg == last_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            base_reg       <= 32'd0;
            data_reg       <= 32'd0;
            last_reg       <= 2'd0;
            index_reg      <= 2'd0;
            req_ready_reg  <= 1'b1;
            mem_wvalid_reg <= 1'b0;
            mem_waddr_reg  <= 32'd0;
            mem_wdata_reg  <= 8'd0;
            done_reg       <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            if (state_reg == IDLE) begin
                // req_ready_reg is high throughout IDLE.
                if (bus.req_valid) begin
                    if (req_legal) begin
                        base_reg       <= bus.req_addr;
                        data_reg       <= req_trunc;
                        last_reg       <= req_last;
                        index_reg      <= 2'd0;
                        mem_wvalid_reg <= 1'b1;
                        mem_waddr_reg  <= beat_addr;
                        mem_wdata_reg  <= beat_data;
                        req_ready_reg  <= 1'b0;
                        state_reg      <= SEND;
                    end else begin
                        fault_reg <= 1'b1;
                    end
                end
            end else begin
                if (beat_fire) begin
                    if (last_beat) begin
                        mem_wvalid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        done_reg       <= 1'b1;
                        index_reg      <= 2'd0;
                        state_reg      <= IDLE;
                    end else begin
                        index_reg     <= src_index;
                        mem_waddr_reg <= beat_addr;
                        mem_wdata_reg <= beat_data;
                    end
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.mem_wvalid = mem_wvalid_reg;
    assign bus.mem_waddr  = mem_waddr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.done       = done_reg;
    assign bus.fault      = fault_reg;

endmodule

// File: tb/tb_store_narrow_unit.sv
// ---------------------------------------------------------------------------
// tb_store_narrow_unit
//   Drives a big-endian and a little-endian instance with identical stimulus.
//   Expected beats are pushed to one queue per instance when a request is
//   issued and popped by a monitor on the falling edge whenever a beat is
//   taken. Request tasks also check latency, done/fault timing and ready.
// ---------------------------------------------------------------------------
module tb_store_narrow_unit;

    logic clk;
    logic reset;

    store_narrow_unit_if if_be ();
    store_narrow_unit_if if_le ();

    store_narrow_unit #(.BIG_ENDIAN(1'b1)) dut_be (
        .clk   (clk),
        .reset (reset),
        .bus   (if_be.slave)
    );

    store_narrow_unit #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk   (clk),
        .reset (reset),
        .bus   (if_le.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    beat_t exp_q0[$];
    beat_t exp_q1[$];

    int total = 0;
    int bad   = 0;
    int exp_done  = 0;
    int exp_fault = 0;
    int done_cnt  [2];
    int fault_cnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s);
        if_be.req_valid = v; if_be.req_addr = a; if_be.req_data = d; if_be.req_size = s;
        if_le.req_valid = v; if_le.req_addr = a; if_le.req_data = d; if_le.req_size = s;
    endtask

    task automatic set_wready(input logic w);
        if_be.mem_wready = w;
        if_le.mem_wready = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    task automatic push_beats(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        logic [31:0] v;
        n = size_bytes(s);
        for (int i = 0; i < n; i++) begin
            v = d >> (8 * (n - 1 - i));
            exp_q0.push_back('{addr: a + 32'(i), data: v[7:0]});
            v = d >> (8 * i);
            exp_q1.push_back('{addr: a + 32'(i), data: v[7:0]});
        end
    endtask

    // Issue a legal store in the current cycle and follow it to done.
    // stalls: cycles mem_wready is held low on the first beat.
    task automatic do_store(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input int stalls);
        int n;
        int cyc;
        n = size_bytes(s);
        check({name, "_rdy_in"}, {31'd0, if_be.req_ready}, 32'd1);
        push_beats(a, d, s);
        drive_req(1'b1, a, d, s);
        set_wready(stalls == 0);
        tick();
        // Garbage on the request bus must be ignored during SEND.
        drive_req(1'b0, $urandom, $urandom, 2'($urandom));
        cyc = 1;
        check({name, "_first_valid_be"}, {31'd0, if_be.mem_wvalid}, 32'd1);
        check({name, "_first_valid_le"}, {31'd0, if_le.mem_wvalid}, 32'd1);
        check({name, "_busy_rdy"}, {31'd0, if_be.req_ready}, 32'd0);
        while (cyc <= 64) begin
            if (if_be.done) break;
            set_wready(cyc > stalls);
            tick();
            cyc++;
        end
        exp_done++;
        check({name, "_done_cycle"}, 32'(cyc), 32'(n + stalls + 1));
        check({name, "_done_le"}, {31'd0, if_le.done}, 32'd1);
        check({name, "_rdy_at_done"}, {30'd0, if_be.req_ready, if_le.req_ready}, 32'd3);
        check({name, "_idle_valid"}, {30'd0, if_be.mem_wvalid, if_le.mem_wvalid}, 32'd0);
    endtask

    task automatic do_fault(input string name, input logic [31:0] a, input logic [1:0] s);
        drive_req(1'b1, a, 32'hA5A5_5A5A, s);
        tick();
        drive_req(1'b0, 32'd0, 32'd0, 2'd0);
        exp_fault++;
        check({name, "_fault"}, {30'd0, if_be.fault, if_le.fault}, 32'd3);
        check({name, "_rdy"}, {30'd0, if_be.req_ready, if_le.req_ready}, 32'd3);
        check({name, "_no_beat"}, {30'd0, if_be.mem_wvalid, if_le.mem_wvalid}, 32'd0);
        check({name, "_no_done"}, {30'd0, if_be.done, if_le.done}, 32'd0);
        tick();
        check({name, "_fault_pulse"}, {30'd0, if_be.fault, if_le.fault}, 32'd0);
        check({name, "_no_beat2"}, {30'd0, if_be.mem_wvalid, if_le.mem_wvalid}, 32'd0);
    endtask

    // Monitor: scoreboard pops, stability under backpressure, pulse counts.
    logic        prev_wait [2];
    logic [31:0] prev_addr [2];
    logic [7:0]  prev_data [2];
    logic        m_v, m_w, m_dn, m_ft;
    logic [31:0] m_a;
    logic [7:0]  m_d;
    beat_t       m_exp;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                m_v = if_be.mem_wvalid; m_w = if_be.mem_wready; m_a = if_be.mem_waddr;
                m_d = if_be.mem_wdata;  m_dn = if_be.done;      m_ft = if_be.fault;
            end else begin
                m_v = if_le.mem_wvalid; m_w = if_le.mem_wready; m_a = if_le.mem_waddr;
                m_d = if_le.mem_wdata;  m_dn = if_le.done;      m_ft = if_le.fault;
            end
            if (reset) begin
                prev_wait[i] = 1'b0;
            end else begin
                if (prev_wait[i]) begin
                    check("hold_valid", {31'd0, m_v}, 32'd1);
                    check("hold_addr", m_a, prev_addr[i]);
                    check("hold_data", {24'd0, m_d}, {24'd0, prev_data[i]});
                end
                if (m_dn && m_ft) check("done_fault_excl", {31'd0, m_dn & m_ft}, 32'd0);
                done_cnt[i]  += int'(m_dn);
                fault_cnt[i] += int'(m_ft);
                if (m_v && m_w) begin
                    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        check("unexpected_beat", m_a, 32'hxxxx_xxxx);
                    end else begin
                        m_exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        $display("beat inst=%0d addr=%h data=%h exp_addr=%h exp_data=%h",
                                 i, m_a, m_d, m_exp.addr, m_exp.data);
                        check(i == 0 ? "beat_addr_be" : "beat_addr_le", m_a, m_exp.addr);
                        check(i == 0 ? "beat_data_be" : "beat_data_le",
                              {24'd0, m_d}, {24'd0, m_exp.data});
                    end
                end
                prev_wait[i] = m_v && !m_w;
                prev_addr[i] = m_a;
                prev_data[i] = m_d;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rs;
        logic [31:0] ra;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0; fault_cnt[i] = 0; prev_wait[i] = 1'b0;
        end
        reset = 1'b1;
        drive_req(1'b0, 32'd0, 32'd0, 2'd0);
        set_wready(1'b1);
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        check("rst_ready", {30'd0, if_be.req_ready, if_le.req_ready}, 32'd3);
        check("rst_wvalid", {30'd0, if_be.mem_wvalid, if_le.mem_wvalid}, 32'd0);
        check("rst_waddr", if_be.mem_waddr | if_le.mem_waddr, 32'd0);
        check("rst_wdata", {24'd0, if_be.mem_wdata | if_le.mem_wdata}, 32'd0);
        check("rst_done_fault", {28'd0, if_be.done, if_le.done, if_be.fault, if_le.fault}, 32'd0);
        tick();

        do_store("byte", 32'h0000_1003, 32'hDEAD_BE5A, 2'b00, 0);
        tick();
        do_store("half_bp", 32'h0000_2002, 32'h1234_ABCD, 2'b01, 2);
        tick();
        do_store("word", 32'h0000_3000, 32'h1122_3344, 2'b10, 0);
        tick();

        do_fault("mis_word", 32'h0000_3002, 2'b10);
        do_fault("mis_half", 32'h0000_2001, 2'b01);
        do_fault("bad_size", 32'h0000_0000, 2'b11);

        // Wrap, then a byte store accepted in the done cycle.
        do_store("wrap", 32'hFFFF_FFFC, 32'hA1B2_C3D4, 2'b10, 0);
        do_store("b2b", 32'h0000_0010, 32'h0000_0077, 2'b00, 0);
        tick();

        // Reset in the middle of a word store, with beat 2 pending.
        push_beats(32'h0000_4000, 32'hCAFE_F00D, 2'b10);
        drive_req(1'b1, 32'h0000_4000, 32'hCAFE_F00D, 2'b10);
        set_wready(1'b1);
        tick();
        drive_req(1'b0, 32'd0, 32'd0, 2'd0);
        tick();
        tick();
        set_wready(1'b0);
        reset = 1'b1;
        tick();
        check("midrst_wvalid", {30'd0, if_be.mem_wvalid, if_le.mem_wvalid}, 32'd0);
        check("midrst_done", {30'd0, if_be.done, if_le.done}, 32'd0);
        check("midrst_ready", {30'd0, if_be.req_ready, if_le.req_ready}, 32'd3);
        check("midrst_left", 32'(exp_q0.size() + exp_q1.size()), 32'd4);
        exp_q0.delete();
        exp_q1.delete();
        reset = 1'b0;
        set_wready(1'b1);
        tick();
        do_store("post_rst", 32'h0000_5001, 32'h0000_00E7, 2'b00, 0);
        tick();

        // A few random legal stores with random first-beat stalls.
        for (int k = 0; k < 6; k++) begin
            rs = 2'($urandom_range(0, 2));
            ra = $urandom;
            if (rs == 2'b01) ra[0] = 1'b0;
            if (rs == 2'b10) ra[1:0] = 2'b00;
            do_store("rand", ra, $urandom, rs, $urandom_range(0, 2));
        end
        repeat (3) tick();

        check("q_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        check("done_count_be", 32'(done_cnt[0]), 32'(exp_done));
        check("done_count_le", 32'(done_cnt[1]), 32'(exp_done));
        check("fault_count_be", 32'(fault_cnt[0]), 32'(exp_fault));
        check("fault_count_le", 32'(fault_cnt[1]), 32'(exp_fault));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
